bicycle_light_decoder: RTL
==========================

# bicycle_light_decoder

Monitors the `rear_light` waveform driven by the bicycle light FSM and recovers the light mode from it. Classifies the light as off, steadily on, or blinking, and measures the high and low segment lengths of the blink in beats. Consumes the same 1/32 s beat pulse that the blinkers use. Sits beside the light FSM as the receiving end of the `rear_light` line, feeding status LEDs and the self-check logic.

## Interface
- `CNT_W`, 8: width of the segment counter and the length outputs.
- `TIMEOUT`, 48: beats without an edge before the light is declared static. Must satisfy 1 < `TIMEOUT` < 2^`CNT_W`.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `beat`  in  1  one-cycle tick, nominally every 1/32 s.
- `rear_light`  in  1  light waveform, synchronous to `clk`.
- `mode`  out  2  00 UNKNOWN, 01 OFF, 10 ON, 11 BLINK.
- `high_len`  out  `CNT_W`  beats in the last complete high segment. Valid in BLINK, otherwise 0.
- `low_len`  out  `CNT_W`  beats in the last complete low segment. Valid in BLINK, otherwise 0.
- `mode_change`  out  1  one-cycle pulse, coincident with the first cycle a new `mode` value is visible.

## Operation
- **Edge detect**
  - `light_q` registers `rear_light` every cycle.
  - `edge` is `rear_light != light_q`.
  - A rising edge closes a low segment; a falling edge closes a high segment.
- **Segment counter `seg_cnt`**
  - On an edge cycle: captures the closing segment length as `seg_cnt` and clears to 0. A `beat` in the same cycle is ignored.
  - Otherwise: increments on `beat` and saturates at `TIMEOUT`.
- **States**
  - **S_UNK** (after reset): `mode` = UNKNOWN.
    - Edge → S_ACQ1.
  - **S_STATIC**: `mode` = OFF if `light_q` = 0, ON if `light_q` = 1.
    - Edge → S_ACQ1. `mode` holds its OFF/ON value.
  - **S_ACQ1**: first edge seen; no full segment measured yet.
    - Edge with captured length ≥ 1 → S_ACQ2. Store the length into the high or low holding register, by edge polarity.
    - Edge with captured length 0 → stay in S_ACQ1 (glitch; restart).
  - **S_ACQ2**: one segment measured.
    - Edge with captured length ≥ 1 → S_BLINK. Load both `high_len` and `low_len`; `mode` = BLINK.
    - Edge with captured length 0 → S_ACQ1. Holding registers are cleared.
  - **S_BLINK**:
    - Each edge with length ≥ 1 updates only the register for the closing segment. `mode` is unchanged and there is no pulse.
    - Edge with length 0 → S_ACQ1. `mode` stays BLINK and the lengths hold.
- **Timeout (all states)**
  - When `seg_cnt` reaches `TIMEOUT` with no edge in that cycle → S_STATIC. `mode` becomes OFF/ON from `light_q`; `high_len` and `low_len` are cleared to 0.
  - Timeout while already S_STATIC at the same level is a no-op: `seg_cnt` stays saturated and there is no pulse.
- **Simultaneous events**
  - An edge in the same cycle as `seg_cnt` = `TIMEOUT` is treated as an edge. The captured length equals `TIMEOUT`, which counts as ≥ 1 for state-transition purposes.
- **`mode_change`**
  - Asserts only when the registered `mode` value actually changes.
  - Does not assert for a BLINK→BLINK reacquisition or for ON→ON.

## Timing
- **Reset values** (applied on the next `clk` edge with `reset` = 1):
  - `light_q` = `rear_light` (so no false edge out of reset).
  - `seg_cnt` = 0.
  - State = S_UNK.
  - `mode` = 00, `high_len` = 0, `low_len` = 0, `mode_change` = 0.
- **Reset mid-operation**: outputs read UNKNOWN/0 in the cycle after reset is sampled, with no `mode_change` pulse. Reset overrides all other events.
- **Latency, edge path**: an edge present in cycle N (`rear_light` changed in N) updates `mode`, the lengths and `mode_change` in cycle N+1.
- **Latency, timeout path**: a timeout becomes visible the cycle after the `beat` that brings `seg_cnt` to `TIMEOUT`.
- **Blink detection time**: three edges after steady state.
- **ON/OFF detection time**: `TIMEOUT` beats after the last edge.
- All outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan
- **Static ON from reset**: reset with `rear_light` = 1, `beat` every 4 clk, no edges.
  - `mode` stays 00 for 47 beats.
  - One cycle after the 48th beat: `mode` = 10 and `mode_change` pulses once.
  - No further pulses while the input stays static.
- **Symmetric blink**: square wave of 8 beats high / 8 beats low starting from OFF.
  - One cycle after the third edge: `mode` = 11, `high_len` = 8, `low_len` = 8, one `mode_change`.
- **Rate change in BLINK**: switch the wave to 4 high / 12 low.
  - `high_len` becomes 4 after the next falling edge.
  - `low_len` becomes 12 after the next rising edge.
  - `mode_change` stays 0.
- **Blink stops**: wave stops with `rear_light` = 0.
  - Exactly 48 beats after the last edge, `mode` = 01.
  - `high_len` and `low_len` = 0, `mode_change` pulses once.
- **Glitch**:
  - In S_ACQ2, a 2-clk pulse with no `beat` inside it sends the state to S_ACQ1 and `mode` is unchanged.
  - In S_BLINK, the same glitch keeps `mode` = 11 and the lengths unchanged, then reacquires with no pulse.
- **Reset mid-BLINK**: assert `reset` for one cycle while blinking 8/8.
  - Next cycle: `mode` = 00, lengths 0, `mode_change` = 0.
  - BLINK is reacquired after three further edges.

Source files
------------

// File: rtl/bicycle_light_decoder_if.sv
// Connects the rear_light monitor to its waveform source (master) and to the status consumers.
interface bicycle_light_decoder_if #(
  parameter int CNT_W = 8
);
  logic             beat;
  logic             rear_light;
  logic [1:0]       mode;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             mode_change;

  modport master (
    output beat, rear_light,
    input  mode, high_len, low_len, mode_change
  );

  modport slave (
    input  beat, rear_light,
    output mode, high_len, low_len, mode_change
  );
endinterface

// File: rtl/bicycle_light_decoder.sv
// Recovers OFF/ON/BLINK and blink segment lengths (in beats) from the rear_light waveform.
// All outputs registered: an edge in cycle N is reflected in N+1; a timeout the cycle after its beat.
module bicycle_light_decoder #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 48
) (
  input  logic                    clk,
  input  logic                    reset,
  bicycle_light_decoder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_UNK,
    S_STATIC,
    S_ACQ1,
    S_ACQ2,
    S_BLINK
  } state_e;

  localparam logic [1:0]       M_UNK   = 2'b00;
  localparam logic [1:0]       M_OFF   = 2'b01;
  localparam logic [1:0]       M_ON    = 2'b10;
  localparam logic [1:0]       M_BLINK = 2'b11;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             light_q;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic [CNT_W-1:0] hold_hi_q, hold_hi_d;
  logic [CNT_W-1:0] hold_lo_q, hold_lo_d;
  logic             mode_change_q, mode_change_d;

  logic edge_s;
  logic rising;
  logic seg_nz;
  logic timeout;

  always_comb begin
    edge_s  = bus.rear_light != light_q;
    rising  = edge_s & bus.rear_light;
    seg_nz  = seg_cnt_q != '0;

    seg_cnt_d = seg_cnt_q;
    if (edge_s) begin
      seg_cnt_d = '0;
    end else if (bus.beat && seg_cnt_q != TO_VAL) begin
      seg_cnt_d = seg_cnt_q + ONE;
    end

    // An edge always wins over a coincident timeout
    timeout = !edge_s && (seg_cnt_d == TO_VAL);

    state_d    = state_q;
    mode_d     = mode_q;
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    hold_hi_d  = hold_hi_q;
    hold_lo_d  = hold_lo_q;

    if (edge_s) begin
      case (state_q)
        S_UNK, S_STATIC: begin
          state_d   = S_ACQ1;
          hold_hi_d = '0;
          hold_lo_d = '0;
        end
        S_ACQ1: begin
          if (seg_nz) begin
            state_d = S_ACQ2;
            if (rising) hold_lo_d = seg_cnt_q;
            else        hold_hi_d = seg_cnt_q;
          end
        end
        S_ACQ2: begin
          if (seg_nz) begin
            state_d = S_BLINK;
            mode_d  = M_BLINK;
            if (rising) begin
              low_len_d  = seg_cnt_q;
              high_len_d = hold_hi_q;
            end else begin
              high_len_d = seg_cnt_q;
              low_len_d  = hold_lo_q;
            end
          end else begin
            state_d   = S_ACQ1;
            hold_hi_d = '0;
            hold_lo_d = '0;
          end
        end
        S_BLINK: begin
          if (seg_nz) begin
            if (rising) low_len_d  = seg_cnt_q;
            else        high_len_d = seg_cnt_q;
          end else begin
            state_d   = S_ACQ1;
            hold_hi_d = '0;
            hold_lo_d = '0;
          end
        end
        default: state_d = S_UNK;
      endcase
    end else if (timeout) begin
      state_d    = S_STATIC;
      mode_d     = light_q ? M_ON : M_OFF;
      high_len_d = '0;
      low_len_d  = '0;
    end

    mode_change_d = mode_d != mode_q;
  end

  always_ff @(posedge clk) begin
    // Tracking the input through reset avoids a false edge on release
    light_q <= bus.rear_light;
    if (reset) begin
      seg_cnt_q     <= '0;
      state_q       <= S_UNK;
      mode_q        <= M_UNK;
      high_len_q    <= '0;
      low_len_q     <= '0;
      hold_hi_q     <= '0;
      hold_lo_q     <= '0;
      mode_change_q <= 1'b0;
    end else begin
      seg_cnt_q     <= seg_cnt_d;
      state_q       <= state_d;
      mode_q        <= mode_d;
      high_len_q    <= high_len_d;
      low_len_q     <= low_len_d;
      hold_hi_q     <= hold_hi_d;
      hold_lo_q     <= hold_lo_d;
      mode_change_q <= mode_change_d;
    end
  end

  assign bus.mode        = mode_q;
  assign bus.high_len    = high_len_q;
  assign bus.low_len     = low_len_q;
  assign bus.mode_change = mode_change_q;

endmodule
